// File: rtl/lpddr4_dly_pkg.sv
// Shared definitions for the LPDDR4 delay-line blocks.
//   NTAP_DEF     : default number of taps on the delay line
//   tap_idx_t    : tap index type for the default 32-tap line
//   tsel_state_e : states of the tap latency selector
package lpddr4_dly_pkg;

    localparam int NTAP_DEF = 32;

    typedef logic [4:0] tap_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CAL   = 2'd2
    } tsel_state_e;

endpackage

// File: rtl/tap_latency_select_if.sv
// Control / calibration handshake bundle of tap_latency_select.
//   i_lat_req, i_lat          : latency change request and requested tap
//   o_lat_ack, o_lat_cur      : change applied pulse, tap currently selected
//   o_busy                    : selector is draining or calibrating
//   i_cal_start, i_cal_echo   : calibration start pulse, returned marker
//   o_cal_done, o_cal_lat     : measurement complete pulse, measured count
//   o_cal_timeout             : no echo seen within the measurement window
// master = requester side, slave = tap_latency_select.
interface tap_latency_select_if #(
    parameter int NTAP = 32
);
    localparam int IW = $clog2(NTAP);

    logic          i_lat_req;
    logic [IW-1:0] i_lat;
    logic          o_lat_ack;
    logic [IW-1:0] o_lat_cur;
    logic          o_busy;
    logic          i_cal_start;
    logic          i_cal_echo;
    logic          o_cal_done;
    logic [IW-1:0] o_cal_lat;
    logic          o_cal_timeout;

    modport master (
        output i_lat_req, i_lat, i_cal_start, i_cal_echo,
        input  o_lat_ack, o_lat_cur, o_busy, o_cal_done, o_cal_lat, o_cal_timeout
    );

    modport slave (
        input  i_lat_req, i_lat, i_cal_start, i_cal_echo,
        output o_lat_ack, o_lat_cur, o_busy, o_cal_done, o_cal_lat, o_cal_timeout
    );

endinterface

// File: rtl/tap_range_quiet.sv
// Combinational quiet detector over a window of the tapped bus.
//   i_taps  : tap bus, tap k = i_taps[k*WIDTH +: WIDTH], bit 0 of a tap = valid
//   i_lo    : lowest tap index of the window (inclusive)
//   i_hi    : highest tap index of the window (inclusive)
//   o_quiet : 1 when no tap in [i_lo, i_hi] carries a valid
module tap_range_quiet #(
    parameter int WIDTH = 1,
    parameter int NTAP  = 32
) (
    input  logic [NTAP*WIDTH-1:0]    i_taps,
    input  logic [$clog2(NTAP)-1:0]  i_lo,
    input  logic [$clog2(NTAP)-1:0]  i_hi,
    output logic                     o_quiet
);
    localparam int IW = $clog2(NTAP);

    logic w_any;

    always_comb begin
        w_any = 1'b0;
        for (int k = 0; k < NTAP; k++) begin
            if ((IW'(k) >= i_lo) && (IW'(k) <= i_hi) && i_taps[k*WIDTH]) begin
                w_any = 1'b1;
            end
        end
    end

    assign o_quiet = ~w_any;

endmodule

// File: rtl/tap_latency_select.sv
// Consumer end of the delay line: selects one tap as a programmable-latency
// output and switches latency only while every valid between the old and the
// new tap has drained, so no valid is dropped or duplicated. Also measures the
// loop latency from a calibration start pulse to its returned echo.
//   clk, rst      : clock, synchronous active-high reset
//   i_taps        : tap bus, tap 0 newest
//   o_d, o_vld    : registered selected tap and its valid bit
//   ctl (slave)   : latency request/ack and calibration handshake
module tap_latency_select
    import lpddr4_dly_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int NTAP    = NTAP_DEF,
    parameter int RST_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NTAP*WIDTH-1:0] i_taps,
    output logic [WIDTH-1:0]      o_d,
    output logic                  o_vld,
    tap_latency_select_if.slave   ctl
);
    localparam int            IW       = $clog2(NTAP);
    localparam logic [IW-1:0] LAST_CNT = IW'(NTAP - 1);
    localparam logic [IW-1:0] RST_IDX  = IW'(RST_LAT);

    tsel_state_e   r_state,   w_state_nxt;
    logic [IW-1:0] r_lat_cur, w_lat_cur_nxt;
    logic [IW-1:0] r_pend,    w_pend_nxt;
    logic [IW-1:0] r_cnt,     w_cnt_nxt;
    logic [IW-1:0] r_cal_lat, w_cal_lat_nxt;
    logic          r_ack,     w_ack_nxt;
    logic          r_done,    w_done_nxt;
    logic          r_tmo,     w_tmo_nxt;
    logic [WIDTH-1:0] r_d;

    logic [WIDTH-1:0] w_sel;
    logic [IW-1:0]    w_lo;
    logic [IW-1:0]    w_hi;
    logic             w_quiet;
    logic [IW-1:0]    w_cnt_inc;

    // ---- tap mux and output register ----
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NTAP; k++) begin
            if (IW'(k) == r_lat_cur) begin
                w_sel = i_taps[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d <= '0;
        end else begin
            r_d <= w_sel;
        end
    end

    assign o_d   = r_d;
    assign o_vld = r_d[0];

    // ---- drain window: every tap between the old and new selection ----
    assign w_lo = (r_lat_cur < r_pend) ? r_lat_cur : r_pend;
    assign w_hi = (r_lat_cur < r_pend) ? r_pend : r_lat_cur;

    tap_range_quiet #(
        .WIDTH (WIDTH),
        .NTAP  (NTAP)
    ) u_quiet (
        .i_taps  (i_taps),
        .i_lo    (w_lo),
        .i_hi    (w_hi),
        .o_quiet (w_quiet)
    );

    // Count value for the current CAL cycle; the first cycle in CAL reads 1.
    assign w_cnt_inc = r_cnt + IW'(1);

    // ---- control FSM: next state ----
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cur_nxt = r_lat_cur;
        w_pend_nxt    = r_pend;
        w_cnt_nxt     = r_cnt;
        w_cal_lat_nxt = r_cal_lat;
        w_ack_nxt     = 1'b0;
        w_done_nxt    = 1'b0;
        w_tmo_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                // A latency request takes priority; a simultaneous cal start is dropped.
                if (ctl.i_lat_req) begin
                    w_pend_nxt = ctl.i_lat;
                    if (ctl.i_lat == r_lat_cur) begin
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else if (ctl.i_cal_start) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = CAL;
                end
            end
            DRAIN: begin
                if (w_quiet) begin
                    w_lat_cur_nxt = r_pend;
                    w_ack_nxt     = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            CAL: begin
                w_cnt_nxt = w_cnt_inc;
                // An echo on the last counted cycle still counts as a result.
                if (ctl.i_cal_echo) begin
                    w_cal_lat_nxt = w_cnt_inc;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = IDLE;
                end else if (w_cnt_inc == LAST_CNT) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---- control FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lat_cur <= RST_IDX;
            r_pend    <= RST_IDX;
            r_cnt     <= '0;
            r_cal_lat <= '0;
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cur <= w_lat_cur_nxt;
            r_pend    <= w_pend_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cal_lat <= w_cal_lat_nxt;
            r_ack     <= w_ack_nxt;
            r_done    <= w_done_nxt;
            r_tmo     <= w_tmo_nxt;
        end
    end

    assign ctl.o_lat_ack     = r_ack;
    assign ctl.o_lat_cur     = r_lat_cur;
    assign ctl.o_busy        = (r_state != IDLE);
    assign ctl.o_cal_done    = r_done;
    assign ctl.o_cal_lat     = r_cal_lat;
    assign ctl.o_cal_timeout = r_tmo;

endmodule

// File: tb/tb_tap_latency_select.sv
// Directed bench for tap_latency_select with a 32-tap delay line model driven
// by a single valid input. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_tap_latency_select;

    localparam int NTAP = 32;
    localparam int W    = 1;

    logic              clk;
    logic              rst;
    logic              din;
    logic [NTAP-2:0]   r_line;
    logic [NTAP*W-1:0] w_taps;
    logic [W-1:0]      o_d;
    logic              o_vld;

    int n_chk;
    int n_bad;

    tap_latency_select_if #(.NTAP(NTAP)) u_if ();

    tap_latency_select #(
        .WIDTH   (W),
        .NTAP    (NTAP),
        .RST_LAT (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_taps (w_taps),
        .o_d    (o_d),
        .o_vld  (o_vld),
        .ctl    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tap 0 is the current input, tap k is the input delayed by k cycles.
    always @(posedge clk) r_line <= {r_line[NTAP-3:0], din};
    assign w_taps = {r_line, din};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Launch a single valid into tap 0 and check when and how often it appears on o_vld.
    task automatic measure(input string tag, input int exp_delay);
        int first;
        int hits;
        first = -1;
        hits  = 0;
        din   = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (o_vld) begin
                hits++;
                if (first < 0) first = i;
            end
            if (i == 1) din = 1'b0;
        end
        chk({tag, "_delay"}, first, exp_delay);
        chk({tag, "_hits"}, hits, 1);
    endtask

    initial begin
        int vcnt;
        int ack_at;
        int busy_seen;
        int cal_ev;

        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        din   = 1'b0;
        r_line = '0;
        u_if.i_lat_req   = 1'b0;
        u_if.i_lat       = '0;
        u_if.i_cal_start = 1'b0;
        u_if.i_cal_echo  = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_vld",     o_vld, 0);
        chk("rst_d",       o_d, 0);
        chk("rst_ack",     u_if.o_lat_ack, 0);
        chk("rst_busy",    u_if.o_busy, 0);
        chk("rst_done",    u_if.o_cal_done, 0);
        chk("rst_cal_lat", u_if.o_cal_lat, 0);
        chk("rst_tmo",     u_if.o_cal_timeout, 0);
        chk("rst_lat_cur", u_if.o_lat_cur, 3);
        rst = 1'b0;
        step();
        measure("lat3", 4);

        // Switch 3 -> 10 with an empty line
        u_if.i_lat_req = 1'b1;
        u_if.i_lat     = 5'd10;
        step();
        u_if.i_lat_req = 1'b0;
        chk("drain_busy", u_if.o_busy, 1);
        chk("drain_noack", u_if.o_lat_ack, 0);
        step();
        chk("sw10_ack", u_if.o_lat_ack, 1);
        chk("sw10_cur", u_if.o_lat_cur, 10);
        chk("sw10_busy", u_if.o_busy, 0);
        step();
        chk("sw10_ack_pulse", u_if.o_lat_ack, 0);
        measure("lat10", 11);

        // Back down to 3 with an empty line
        u_if.i_lat_req = 1'b1;
        u_if.i_lat     = 5'd3;
        step();
        u_if.i_lat_req = 1'b0;
        step();
        chk("sw3_ack", u_if.o_lat_ack, 1);
        chk("sw3_cur", u_if.o_lat_cur, 3);
        step();

        // Switch 3 -> 10 while an 8-cycle burst occupies the window
        vcnt   = 0;
        ack_at = -1;
        for (int i = 0; i <= 30; i++) begin
            if (i > 0) begin
                if (o_vld) vcnt++;
                if (u_if.o_lat_ack) ack_at = i;
                if (i == 10) chk("burst_busy", u_if.o_busy, 1);
            end
            if (i == 0) din = 1'b1;
            if (i == 8) din = 1'b0;
            if (i == 2) begin
                u_if.i_lat_req = 1'b1;
                u_if.i_lat     = 5'd10;
            end
            if (i == 3) u_if.i_lat_req = 1'b0;
            step();
        end
        chk("burst_ack_at", ack_at, 19);
        chk("burst_vld_cnt", vcnt, 8);
        chk("burst_cur", u_if.o_lat_cur, 10);
        repeat (12) step();

        // Request equal to current latency
        busy_seen = 0;
        u_if.i_lat_req = 1'b1;
        u_if.i_lat     = 5'd10;
        step();
        u_if.i_lat_req = 1'b0;
        if (u_if.o_busy) busy_seen = 1;
        chk("same_ack", u_if.o_lat_ack, 1);
        step();
        if (u_if.o_busy) busy_seen = 1;
        chk("same_ack_pulse", u_if.o_lat_ack, 0);
        chk("same_busy", busy_seen, 0);
        chk("same_cur", u_if.o_lat_cur, 10);

        // Echo outside CAL is ignored
        u_if.i_cal_echo = 1'b1;
        step();
        u_if.i_cal_echo = 1'b0;
        step();
        chk("echo_idle_done", u_if.o_cal_done, 0);
        chk("echo_idle_busy", u_if.o_busy, 0);

        // Calibration with echo 7 cycles after start
        u_if.i_cal_start = 1'b1;
        step();
        u_if.i_cal_start = 1'b0;
        chk("cal_busy", u_if.o_busy, 1);
        repeat (6) step();
        chk("cal_early_done", u_if.o_cal_done, 0);
        u_if.i_cal_echo = 1'b1;
        step();
        u_if.i_cal_echo = 1'b0;
        chk("cal_done", u_if.o_cal_done, 1);
        chk("cal_lat7", u_if.o_cal_lat, 7);
        chk("cal_idle", u_if.o_busy, 0);
        step();
        chk("cal_done_pulse", u_if.o_cal_done, 0);

        // Calibration without echo
        u_if.i_cal_start = 1'b1;
        step();
        u_if.i_cal_start = 1'b0;
        repeat (30) step();
        chk("tmo_early", u_if.o_cal_timeout, 0);
        chk("tmo_busy", u_if.o_busy, 1);
        step();
        chk("tmo_pulse", u_if.o_cal_timeout, 1);
        chk("tmo_lat_kept", u_if.o_cal_lat, 7);
        chk("tmo_idle", u_if.o_busy, 0);
        step();
        chk("tmo_pulse_end", u_if.o_cal_timeout, 0);

        // Echo on the final counted cycle
        u_if.i_cal_start = 1'b1;
        step();
        u_if.i_cal_start = 1'b0;
        repeat (30) step();
        u_if.i_cal_echo = 1'b1;
        step();
        u_if.i_cal_echo = 1'b0;
        chk("last_done", u_if.o_cal_done, 1);
        chk("last_tmo", u_if.o_cal_timeout, 0);
        chk("last_lat", u_if.o_cal_lat, 31);
        step();

        // Latency request and cal start together
        u_if.i_lat_req   = 1'b1;
        u_if.i_lat       = 5'd5;
        u_if.i_cal_start = 1'b1;
        step();
        u_if.i_lat_req   = 1'b0;
        u_if.i_cal_start = 1'b0;
        chk("both_busy", u_if.o_busy, 1);
        step();
        chk("both_ack", u_if.o_lat_ack, 1);
        chk("both_cur", u_if.o_lat_cur, 5);
        cal_ev = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (u_if.o_cal_done || u_if.o_cal_timeout || u_if.o_busy) cal_ev++;
        end
        chk("both_no_cal", cal_ev, 0);

        // Reset in the middle of CAL
        u_if.i_cal_start = 1'b1;
        step();
        u_if.i_cal_start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("rstcal_busy", u_if.o_busy, 0);
        chk("rstcal_done", u_if.o_cal_done, 0);
        chk("rstcal_tmo", u_if.o_cal_timeout, 0);
        chk("rstcal_cur", u_if.o_lat_cur, 3);
        chk("rstcal_lat", u_if.o_cal_lat, 0);
        rst = 1'b0;
        cal_ev = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (u_if.o_cal_done || u_if.o_cal_timeout) cal_ev++;
        end
        chk("rstcal_no_pulse", cal_ev, 0);
        measure("lat_after_rst", 4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
